aes_ks_store: RTL and testbench

- Multi-context AES key-expansion engine with round-key storage.
- Expands a 128/192/256-bit cipher key once into a per-slot round-key store, one 32-bit word per cycle.
- Afterwards serves any round key by random index, in forward (encrypt) or reversed (decrypt) order, with 1-cycle latency.
- Sits beside the AES datapath; lets the core switch between NUM_SLOTS preloaded keys without re-expanding.

---
 rtl/aes_ks_store_if.sv | 34 +++
 rtl/aes_ks_store.sv | 208 ++++++++++++++++++++
 tb/tb_aes_ks_store.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/aes_ks_store_if.sv
// Key-load and round-key read bus of the AES key-schedule store.
// The master drives loads and reads, and the slave returns status and round keys.
interface aes_ks_store_if #(
   parameter int NUM_SLOTS = 2
);
   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   logic                 load_i;
   logic [SW-1:0]        slot_i;
   logic [1:0]           size_i;
   logic [255:0]         key_i;
   logic                 busy_o;
   logic                 done_o;
   logic                 load_err_o;
   logic [NUM_SLOTS-1:0] slot_valid_o;
   logic                 rk_req_i;
   logic [SW-1:0]        rk_slot_i;
   logic [3:0]           rk_idx_i;
   logic                 rk_dec_i;
   logic                 rk_valid_o;
   logic                 rk_err_o;
   logic [127:0]         rk_o;
   logic [3:0]           nr_o;

   modport master (
      output load_i, slot_i, size_i, key_i, rk_req_i, rk_slot_i, rk_idx_i, rk_dec_i,
      input  busy_o, done_o, load_err_o, slot_valid_o, rk_valid_o, rk_err_o, rk_o, nr_o
   );

   modport slave (
      input  load_i, slot_i, size_i, key_i, rk_req_i, rk_slot_i, rk_idx_i, rk_dec_i,
      output busy_o, done_o, load_err_o, slot_valid_o, rk_valid_o, rk_err_o, rk_o, nr_o
   );
endinterface

// File: rtl/aes_ks_store.sv
// Multi-slot AES key expansion (128/192/256) producing one word per cycle into a
// round-key store, with a 1-cycle random-access forward/reverse round-key read port.
module aes_ks_store #(
   parameter int NUM_SLOTS  = 2,
   parameter int ENABLE_192 = 1,
   parameter int ENABLE_256 = 1
) (
   input logic          clk,
   input logic          rst_n,
   aes_ks_store_if.slave bus
);
   localparam int SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int DEPTH = NUM_SLOTS * 15;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [SW:0] NS = (SW+1)'(NUM_SLOTS);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_EXPAND = 1'b1;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 = a^(2+4+...+128), followed by the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int unsigned k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   logic [0:0]           state;
   logic [1:0]           size_q;
   logic [SW-1:0]        slot_q;
   logic [31:0]          win [8];
   logic [5:0]           widx;
   logic [2:0]           wmod;
   logic [7:0]           rcon;
   logic [NUM_SLOTS-1:0] slot_valid;
   logic [1:0]           slot_size [NUM_SLOTS];
   logic                 done_q;
   logic                 load_err_q;
   logic [3:0][31:0]     store [DEPTH];

   logic                 size_ok;
   logic                 slot_ok;
   logic                 load_go;
   logic                 load_rej;
   logic [7:0][31:0]     kwin;
   logic [31:0]          prev;
   logic [31:0]          far;
   logic [31:0]          sb_out;
   logic [31:0]          new_w;
   logic [5:0]           last_idx;
   logic [2:0]           nk_m1;
   logic                 last_word;
   logic [AW-1:0]        kbase;
   logic [AW-1:0]        waddr;

   always_comb begin
      size_ok  = (bus.size_i == 2'd0) ||
                 (bus.size_i == 2'd1 && ENABLE_192 != 0) ||
                 (bus.size_i == 2'd2 && ENABLE_256 != 0);
      slot_ok  = {1'b0, bus.slot_i} < NS;
      load_go  = (state == S_IDLE) && bus.load_i && size_ok && slot_ok;
      load_rej = (state == S_IDLE) && bus.load_i && !(size_ok && slot_ok);
      // Right-align the key so w[Nk-1] always lands in win[7] and w[i-Nk] in win[8-Nk].
      case (bus.size_i)
         2'd0:    kwin = {128'h0, bus.key_i[255:128]};
         2'd1:    kwin = {64'h0, bus.key_i[255:64]};
         default: kwin = bus.key_i;
      endcase
      case (size_q)
         2'd0:    begin far = win[4]; last_idx = 6'd43; nk_m1 = 3'd3; end
         2'd1:    begin far = win[2]; last_idx = 6'd51; nk_m1 = 3'd5; end
         default: begin far = win[0]; last_idx = 6'd59; nk_m1 = 3'd7; end
      endcase
      prev   = win[7];
      sb_out = sub_word((wmod == 3'd0) ? {prev[23:0], prev[31:24]} : prev);
      if (wmod == 3'd0)
         new_w = far ^ sb_out ^ {rcon, 24'h0};
      else if (size_q == 2'd2 && wmod == 3'd4)
         new_w = far ^ sb_out;
      else
         new_w = far ^ prev;
      last_word = (widx == last_idx);
      kbase     = AW'(bus.slot_i) * AW'(15);
      waddr     = AW'(slot_q) * AW'(15) + AW'(widx[5:2]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         slot_valid <= '0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         load_err_q <= load_rej;
         if (state == S_IDLE) begin
            if (load_go) begin
               state                   <= S_EXPAND;
               slot_valid[bus.slot_i] <= 1'b0;
            end
         end else if (last_word) begin
            state              <= S_IDLE;
            slot_valid[slot_q] <= 1'b1;
            done_q             <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_go) begin
         size_q                 <= bus.size_i;
         slot_q                 <= bus.slot_i;
         slot_size[bus.slot_i] <= bus.size_i;
         widx <= (bus.size_i == 2'd0) ? 6'd4 : (bus.size_i == 2'd1) ? 6'd6 : 6'd8;
         wmod <= '0;
         rcon <= 8'h01;
         for (int unsigned j = 0; j < 8; j++) win[j] <= kwin[7-j];
         store[kbase] <= bus.key_i[255:128];
         if (bus.size_i != 2'd0) store[kbase + AW'(1)][3:2] <= bus.key_i[127:64];
         if (bus.size_i == 2'd2) store[kbase + AW'(1)][1:0] <= bus.key_i[63:0];
      end else if (state == S_EXPAND) begin
         for (int unsigned j = 0; j < 7; j++) win[j] <= win[j+1];
         win[7] <= new_w;
         widx   <= widx + 6'd1;
         wmod   <= (wmod == nk_m1) ? 3'd0 : wmod + 3'd1;
         if (wmod == 3'd0) rcon <= xtime(rcon);
         store[waddr][~widx[1:0]] <= new_w;
      end
   end

   logic [SW-1:0] rs;
   logic          rslot_ok;
   logic          rvalid_now;
   logic [3:0]    rnr;
   logic [3:0]    ridx;
   logic [AW-1:0] raddr;
   logic          rk_valid_q;
   logic          rk_err_q;
   logic [127:0]  rk_q;
   logic [3:0]    nr_q;

   always_comb begin
      rslot_ok = {1'b0, bus.rk_slot_i} < NS;
      rs       = rslot_ok ? bus.rk_slot_i : '0;
      // A load accepted on this edge invalidates its slot for a coincident read.
      rvalid_now = rslot_ok && slot_valid[rs] && !(load_go && bus.slot_i == rs);
      rnr        = 4'd10 + {1'b0, slot_size[rs], 1'b0};
      ridx       = bus.rk_dec_i ? rnr - bus.rk_idx_i : bus.rk_idx_i;
      raddr      = AW'(rs) * AW'(15) + AW'(ridx);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_valid_q <= 1'b0;
         rk_err_q   <= 1'b0;
         rk_q       <= '0;
         nr_q       <= '0;
      end else begin
         rk_valid_q <= bus.rk_req_i;
         rk_err_q   <= 1'b0;
         if (bus.rk_req_i) begin
            if (rvalid_now && bus.rk_idx_i <= rnr) begin
               rk_q <= store[raddr];
               nr_q <= rnr;
            end else begin
               rk_err_q <= 1'b1;
               rk_q     <= '0;
               nr_q     <= '0;
            end
         end
      end
   end

   assign bus.busy_o       = (state == S_EXPAND);
   assign bus.done_o       = done_q;
   assign bus.load_err_o   = load_err_q;
   assign bus.slot_valid_o = slot_valid;
   assign bus.rk_valid_o   = rk_valid_q;
   assign bus.rk_err_o     = rk_err_q;
   assign bus.rk_o         = rk_q;
   assign bus.nr_o         = nr_q;
endmodule

// File: tb/tb_aes_ks_store.sv
// Directed bench for aes_ks_store: FIPS-197 key schedules, read errors,
// concurrent reads during reload, and reset mid-expansion.
module tb_aes_ks_store;
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total = 0;

   aes_ks_store_if #(.NUM_SLOTS(2)) bus ();

   aes_ks_store #(.NUM_SLOTS(2), .ENABLE_192(1), .ENABLE_256(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic slot, input logic [1:0] size, input logic [255:0] key);
      bus.load_i = 1'b1; bus.slot_i = slot; bus.size_i = size; bus.key_i = key;
      step();
      bus.load_i = 1'b0;
   endtask

   task automatic wait_done(output int n, output int bc);
      n = 0; bc = 0;
      while (n < 200) begin
         if (bus.busy_o) bc++;
         step();
         n++;
         if (bus.done_o) break;
      end
   endtask

   task automatic do_read(input logic slot, input logic [3:0] idx, input logic dec,
                          output logic v, output logic e, output logic [127:0] rk, output logic [3:0] nr);
      bus.rk_req_i = 1'b1; bus.rk_slot_i = slot; bus.rk_idx_i = idx; bus.rk_dec_i = dec;
      step();
      bus.rk_req_i = 1'b0;
      v = bus.rk_valid_o; e = bus.rk_err_o; rk = bus.rk_o; nr = bus.nr_o;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %0h exp 0", bus.busy_o); else pass_cnt++;
      total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got %0h exp 0", bus.done_o); else pass_cnt++;
      total++; if (bus.load_err_o !== 1'b0) $display("FAIL reset_load_err got %0h exp 0", bus.load_err_o); else pass_cnt++;
      total++; if (bus.slot_valid_o !== 2'b00) $display("FAIL reset_slot_valid got %0h exp 0", bus.slot_valid_o); else pass_cnt++;
      total++; if (bus.rk_valid_o !== 1'b0) $display("FAIL reset_rk_valid got %0h exp 0", bus.rk_valid_o); else pass_cnt++;
      total++; if (bus.rk_o !== 128'h0 || bus.nr_o !== 4'h0) $display("FAIL reset_rk got %h/%0d exp 0/0", bus.rk_o, bus.nr_o); else pass_cnt++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_unloaded();
      logic v, e; logic [127:0] rk; logic [3:0] nr;
      do_read(1'b0, 4'd0, 1'b0, v, e, rk, nr);
      total++; if (v !== 1'b1 || e !== 1'b1) $display("FAIL unloaded_err got v%0h e%0h exp v1 e1", v, e); else pass_cnt++;
      total++; if (rk !== 128'h0 || nr !== 4'h0) $display("FAIL unloaded_rk got %h/%0d exp 0/0", rk, nr); else pass_cnt++;
      step();
      total++; if (bus.rk_valid_o !== 1'b0) $display("FAIL rk_valid_one_cycle got %0h exp 0", bus.rk_valid_o); else pass_cnt++;
   endtask

   task automatic test_aes128();
      int n, bc; logic v, e; logic [127:0] rk; logic [3:0] nr;
      start_load(1'b0, 2'd0, K128);
      wait_done(n, bc);
      total++; if (n !== 40) $display("FAIL aes128_done_edge got %0d exp 40", n); else pass_cnt++;
      total++; if (bc !== 40) $display("FAIL aes128_busy_cycles got %0d exp 40", bc); else pass_cnt++;
      total++; if (bus.busy_o !== 1'b0 || bus.slot_valid_o !== 2'b01) $display("FAIL aes128_complete got busy%0h sv%0h exp busy0 sv1", bus.busy_o, bus.slot_valid_o); else pass_cnt++;
      step();
      total++; if (bus.done_o !== 1'b0) $display("FAIL aes128_done_pulse got %0h exp 0", bus.done_o); else pass_cnt++;
      do_read(1'b0, 4'd10, 1'b0, v, e, rk, nr);
      total++; if (v !== 1'b1 || e !== 1'b0 || rk !== R128_10 || nr !== 4'd10) $display("FAIL aes128_rk10 got v%0h e%0h %h nr%0d exp v1 e0 %h nr10", v, e, rk, nr, R128_10); else pass_cnt++;
      do_read(1'b0, 4'd0, 1'b1, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== R128_10) $display("FAIL aes128_dec0 got e%0h %h exp e0 %h", e, rk, R128_10); else pass_cnt++;
      do_read(1'b0, 4'd1, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== R128_1) $display("FAIL aes128_rk1 got e%0h %h exp e0 %h", e, rk, R128_1); else pass_cnt++;
   endtask

   task automatic test_aes192();
      int n, bc; logic v, e; logic [127:0] rk; logic [3:0] nr;
      start_load(1'b1, 2'd1, K192);
      wait_done(n, bc);
      total++; if (bc !== 46 || n !== 46) $display("FAIL aes192_busy_cycles got %0d/%0d exp 46/46", bc, n); else pass_cnt++;
      total++; if (bus.slot_valid_o !== 2'b11) $display("FAIL aes192_slot_valid got %0h exp 3", bus.slot_valid_o); else pass_cnt++;
      do_read(1'b1, 4'd12, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== 128'he98ba06f448c773c8ecc720401002202 || nr !== 4'd12) $display("FAIL aes192_rk12 got e%0h %h nr%0d exp e0 e98ba06f448c773c8ecc720401002202 nr12", e, rk, nr); else pass_cnt++;
      do_read(1'b1, 4'd0, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== 128'h8e73b0f7da0e6452c810f32b809079e5) $display("FAIL aes192_rk0 got e%0h %h exp e0 8e73b0f7da0e6452c810f32b809079e5", e, rk); else pass_cnt++;
   endtask

   task automatic test_errors();
      logic v, e; logic [127:0] rk; logic [3:0] nr;
      start_load(1'b0, 2'd3, K256);
      total++; if (bus.load_err_o !== 1'b1 || bus.busy_o !== 1'b0) $display("FAIL size3_reject got err%0h busy%0h exp err1 busy0", bus.load_err_o, bus.busy_o); else pass_cnt++;
      total++; if (bus.slot_valid_o !== 2'b11) $display("FAIL size3_slot_valid got %0h exp 3", bus.slot_valid_o); else pass_cnt++;
      step();
      total++; if (bus.load_err_o !== 1'b0) $display("FAIL size3_err_pulse got %0h exp 0", bus.load_err_o); else pass_cnt++;
      do_read(1'b0, 4'd11, 1'b0, v, e, rk, nr);
      total++; if (v !== 1'b1 || e !== 1'b1 || rk !== 128'h0 || nr !== 4'h0) $display("FAIL idx11_on_128 got v%0h e%0h %h nr%0d exp v1 e1 0 nr0", v, e, rk, nr); else pass_cnt++;
      do_read(1'b1, 4'd13, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b1) $display("FAIL idx13_on_192 got e%0h exp e1", e); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n, bc;
      logic [3:0]   pidx [5] = '{4'd0, 4'd10, 4'd1, 4'd10, 4'd0};
      logic         pdec [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [127:0] pexp [5] = '{R128_0, R128_10, R128_1, R128_0, R128_10};
      int k;
      logic v, e; logic [127:0] rk; logic [3:0] nr;
      // Reload slot 1 with AES-256 while reading slot 1 on the same edge.
      bus.rk_req_i = 1'b1; bus.rk_slot_i = 1'b1; bus.rk_idx_i = 4'd0; bus.rk_dec_i = 1'b0;
      start_load(1'b1, 2'd2, K256);
      total++; if (bus.rk_valid_o !== 1'b1 || bus.rk_err_o !== 1'b1) $display("FAIL same_cycle_read got v%0h e%0h exp v1 e1", bus.rk_valid_o, bus.rk_err_o); else pass_cnt++;
      total++; if (bus.busy_o !== 1'b1 || bus.slot_valid_o !== 2'b01) $display("FAIL reload_invalidate got busy%0h sv%0h exp busy1 sv1", bus.busy_o, bus.slot_valid_o); else pass_cnt++;
      n = 0; bc = 0;
      while (n < 200) begin
         k = n % 5;
         bus.rk_slot_i = 1'b0; bus.rk_idx_i = pidx[k]; bus.rk_dec_i = pdec[k];
         bus.load_i = (n == 5); bus.slot_i = 1'b0; bus.size_i = 2'd0; bus.key_i = {8{32'hdeadbeef}};
         if (bus.busy_o) bc++;
         step();
         n++;
         total++; if (bus.rk_valid_o !== 1'b1 || bus.rk_err_o !== 1'b0 || bus.rk_o !== pexp[k] || bus.nr_o !== 4'd10) $display("FAIL stream_read n=%0d got v%0h e%0h %h nr%0d exp v1 e0 %h nr10", n, bus.rk_valid_o, bus.rk_err_o, bus.rk_o, bus.nr_o, pexp[k]); else pass_cnt++;
         total++; if (bus.load_err_o !== 1'b0) $display("FAIL busy_load_err n=%0d got %0h exp 0", n, bus.load_err_o); else pass_cnt++;
         if (bus.done_o) break;
         total++; if (bus.slot_valid_o[1] !== 1'b0) $display("FAIL slot1_early_valid n=%0d got 1 exp 0", n); else pass_cnt++;
      end
      bus.load_i = 1'b0; bus.rk_req_i = 1'b0;
      total++; if (bc !== 52 || n !== 52) $display("FAIL aes256_busy_cycles got %0d/%0d exp 52/52", bc, n); else pass_cnt++;
      total++; if (bus.slot_valid_o !== 2'b11) $display("FAIL aes256_slot_valid got %0h exp 3", bus.slot_valid_o); else pass_cnt++;
      step();
      total++; if (bus.rk_valid_o !== 1'b0) $display("FAIL stream_end_valid got %0h exp 0", bus.rk_valid_o); else pass_cnt++;
      do_read(1'b1, 4'd14, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== 128'hfe4890d1e6188d0b046df344706c631e || nr !== 4'd14) $display("FAIL aes256_rk14 got e%0h %h nr%0d exp e0 fe4890d1e6188d0b046df344706c631e nr14", e, rk, nr); else pass_cnt++;
      do_read(1'b1, 4'd13, 1'b1, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== 128'h1f352c073b6108d72d9810a30914dff4) $display("FAIL aes256_dec13 got e%0h %h exp e0 1f352c073b6108d72d9810a30914dff4", e, rk); else pass_cnt++;
      do_read(1'b0, 4'd10, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== R128_10) $display("FAIL busy_load_ignored got e%0h %h exp e0 %h", e, rk, R128_10); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int n, bc; logic v, e; logic [127:0] rk; logic [3:0] nr;
      do_read(1'b1, 4'd14, 1'b0, v, e, rk, nr);
      start_load(1'b0, 2'd0, K128);
      for (int i = 0; i < 19; i++) step();
      total++; if (bus.busy_o !== 1'b1 || bus.rk_o === 128'h0) $display("FAIL mid_pre_reset got busy%0h rk %h exp busy1 rk nonzero", bus.busy_o, bus.rk_o); else pass_cnt++;
      rst_n = 1'b0;
      step();
      total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.load_err_o !== 1'b0) $display("FAIL mid_reset_ctrl got busy%0h done%0h err%0h exp 0 0 0", bus.busy_o, bus.done_o, bus.load_err_o); else pass_cnt++;
      total++; if (bus.slot_valid_o !== 2'b00) $display("FAIL mid_reset_slot_valid got %0h exp 0", bus.slot_valid_o); else pass_cnt++;
      total++; if (bus.rk_valid_o !== 1'b0 || bus.rk_err_o !== 1'b0 || bus.rk_o !== 128'h0 || bus.nr_o !== 4'h0) $display("FAIL mid_reset_rk got v%0h e%0h %h nr%0d exp all 0", bus.rk_valid_o, bus.rk_err_o, bus.rk_o, bus.nr_o); else pass_cnt++;
      rst_n = 1'b1;
      step();
      start_load(1'b0, 2'd0, K128);
      wait_done(n, bc);
      total++; if (n !== 40 || bus.slot_valid_o !== 2'b01) $display("FAIL post_reset_load got n%0d sv%0h exp n40 sv1", n, bus.slot_valid_o); else pass_cnt++;
      do_read(1'b0, 4'd10, 1'b0, v, e, rk, nr);
      total++; if (e !== 1'b0 || rk !== R128_10 || nr !== 4'd10) $display("FAIL post_reset_rk10 got e%0h %h nr%0d exp e0 %h nr10", e, rk, nr, R128_10); else pass_cnt++;
   endtask

   initial begin
      bus.load_i = 1'b0; bus.slot_i = '0; bus.size_i = '0; bus.key_i = '0;
      bus.rk_req_i = 1'b0; bus.rk_slot_i = '0; bus.rk_idx_i = '0; bus.rk_dec_i = 1'b0;
      test_reset();
      test_unloaded();
      test_aes128();
      test_aes192();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
